// File: rtl/mp_main_memory.sv
// mp_main_memory: line-granular shared main memory behind a round-robin arbiter.
// All requestors are served one at a time, which gives a single global memory
// order. Each access completes a programmable LATENCY cycles after acceptance.
// Addresses at or above DEPTH are flagged with resp_err and never alias.
//
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   req_valid/req_ready   per-port request handshake (ready is one-hot or zero)
//   req_we                per-port 1 = write line, 0 = read line
//   req_addr/req_wdata    per-port line address / write data, packed by port
//   resp_valid/resp_ready per-port response handshake (valid is one-hot or zero)
//   resp_rdata/resp_err   shared response payload, qualified by resp_valid
//   busy                  high whenever the FSM is not idle
module mp_main_memory #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LINE_W    = 64,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  input  logic [NUM_PORTS-1:0]        resp_ready,
  output logic [LINE_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic                        busy
);

  localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_MAX = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [PORT_W-1:0]   ptr_q;
  logic [PORT_W-1:0]   ptr_d;
  logic [PORT_W-1:0]   port_q;
  logic                err_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_PORTS-1:0] resp_valid_q;

  logic [LINE_W-1:0]   mem_q [DEPTH];

  logic                grant_vld;
  logic [PORT_W-1:0]   grant_idx;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;
  logic                sel_err;

  // Round-robin arbiter: first valid port at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(ptr_q) + k) % NUM_PORTS;
      if (!grant_vld && req_valid[PORT_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PORT_W'(idx);
      end
    end
  end

  // Requests are only accepted in IDLE and never while reset is asserted.
  assign accept    = grant_vld && (state_q == IDLE) && reset;
  assign req_ready = accept ? (NUM_PORTS'(1) << grant_idx) : '0;

  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[32'(grant_idx) * LINE_W +: LINE_W];
  assign sel_err   = (32'(sel_addr) >= DEPTH);
  assign ptr_d     = PORT_W'((32'(grant_idx) + 1) % NUM_PORTS);

  // Array write commits at acceptance; reset does not clear contents.
  always_ff @(posedge clk) begin
    if (accept && sel_we && !sel_err) begin
      mem_q[sel_addr[IDX_W-1:0]] <= sel_wdata;
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      port_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            port_q  <= grant_idx;
            err_q   <= sel_err;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            rdata_q <= (!sel_we && !sel_err) ? mem_q[sel_addr[IDX_W-1:0]] : '0;
            if (LATENCY > 1) begin
              state_q <= WAIT;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= NUM_PORTS'(1) << grant_idx;
            end
          end
        end
        WAIT: begin
          // Stays here LATENCY-1 cycles so valid rises LATENCY cycles after acceptance.
          if (cnt_q == CNT_W'(CNT_MAX)) begin
            state_q      <= RESP;
            resp_valid_q <= NUM_PORTS'(1) << port_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[port_q]) begin
            state_q      <= IDLE;
            resp_valid_q <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mp_main_memory.sv
// tb_mp_main_memory: scoreboard bench for mp_main_memory. A reference model
// (round-robin order, address-keyed line store, fixed latency) predicts grants,
// busy and every response; a negedge monitor compares the DUT against it.
module tb_mp_main_memory;

  localparam int unsigned NP    = 2;
  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = 64;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned LAT   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*LW-1:0] req_wdata;
  logic [NP-1:0]    resp_valid;
  logic [NP-1:0]    resp_ready;
  logic [LW-1:0]    resp_rdata;
  logic             resp_err;
  logic             busy;

  always #5 clk = ~clk;

  mp_main_memory #(
    .NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  typedef struct {
    int          port;
    logic [LW-1:0] rdata;
    bit          known;
    bit          err;
    int unsigned due;
  } exp_t;

  exp_t          sbq[$];
  logic [LW-1:0] ref_mem [int unsigned];
  int            n_chk = 0;
  int            n_fail = 0;
  int unsigned   cyc = 0;
  bit            m_busy = 1'b0;
  int            m_ptr = 0;
  bit            contend = 1'b0;
  int            last_grant = -1;
  int            wait_cnt [NP];
  logic [NP-1:0] acc;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor + reference model: compare this cycle, then advance the model
  // by what the next rising edge will do.
  always @(negedge clk) begin
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] exp_rv;
    int            g;
    int            p;
    int unsigned   a;
    exp_t          e;
    cyc++;

    g = -1;
    if (reset && !m_busy) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    exp_ready = (g >= 0) ? (NP'(1) << g) : '0;
    exp_rv = '0;
    if (m_busy && sbq.size() > 0 && cyc >= sbq[0].due) exp_rv = NP'(1) << sbq[0].port;

    check("busy", 64'(busy), 64'(m_busy));
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv != '0) begin
      check("resp_err", 64'(resp_err), 64'(sbq[0].err));
      if (sbq[0].known) check("resp_rdata", resp_rdata, sbq[0].rdata);
    end

    if (!contend) last_grant = -1;
    for (int q = 0; q < NP; q++) begin
      if (contend && req_valid[q] && req_ready[q]) begin
        if (last_grant >= 0) check("alternate", 64'(q), 64'(1 - last_grant));
        last_grant = q;
      end
      if (req_valid[q] && !req_ready[q]) wait_cnt[q]++;
      else wait_cnt[q] = 0;
      if (req_valid[q]) check("wait_bound", 64'(wait_cnt[q] > 40), 64'(0));
    end

    if (!reset) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      sbq.delete();
    end else if (exp_rv != '0) begin
      if (resp_ready[sbq[0].port]) begin
        void'(sbq.pop_front());
        m_busy = 1'b0;
      end
    end else if (g >= 0) begin
      a       = 32'(req_addr[g*AW +: AW]);
      e.port  = g;
      e.due   = cyc + LAT;
      e.err   = (a >= DEPTH);
      e.rdata = '0;
      e.known = 1'b1;
      if (!e.err) begin
        if (req_we[g]) ref_mem[a] = req_wdata[g*LW +: LW];
        else if (ref_mem.exists(a)) e.rdata = ref_mem[a];
        else e.known = 1'b0;
      end
      sbq.push_back(e);
      m_busy = 1'b1;
      m_ptr  = (g + 1) % NP;
    end
  end

  task automatic set_req(int p, bit we, logic [AW-1:0] a, logic [LW-1:0] d);
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*LW +: LW] = d;
    req_valid[p]          = 1'b1;
  endtask

  // Hold requests until each is accepted, bounded.
  task automatic serve(int budget);
    for (int i = 0; i < budget && req_valid != '0; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!m_busy && sbq.size() == 0) break;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    return (r < 8) ? AW'(r) : AW'(191 + r);
  endfunction

  initial begin
    int d0;
    int d1;
    reset      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '1;

    // Reset held with every port requesting; port 0 must win first afterwards.
    set_req(0, 1'b1, 8'h10, 64'hDEADBEEF_01234567);
    set_req(1, 1'b0, 8'h10, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    serve(60);
    wait_idle(50);

    // Contention: both ports continuously requesting.
    contend = 1'b1;
    d0 = 0;
    d1 = 0;
    set_req(0, 1'b1, 8'h30, 64'h3030_0000_0000_0001);
    set_req(1, 1'b0, 8'h30, '0);
    for (int i = 0; i < 200 && (d0 < 6 || d1 < 6); i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) begin
        d0++;
        if (d0 < 6) set_req(0, 1'($urandom_range(0, 1)), 8'h30, {$urandom, $urandom});
        else req_valid[0] = 1'b0;
      end
      if (acc[1]) begin
        d1++;
        if (d1 < 6) set_req(1, 1'($urandom_range(0, 1)), 8'h30, {$urandom, $urandom});
        else req_valid[1] = 1'b0;
      end
    end
    req_valid = '0;
    wait_idle(50);
    contend = 1'b0;

    // Backpressure on port 1 while port 0 waits.
    set_req(1, 1'b1, 8'h20, 64'h2020_2020_0BAD_F00D);
    serve(60);
    wait_idle(50);
    resp_ready = 2'b01;
    set_req(1, 1'b0, 8'h20, '0);
    serve(60);
    set_req(0, 1'b1, 8'h21, 64'h2121_2121_2121_2121);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid[1]) break;
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    resp_ready = '1;
    serve(60);
    wait_idle(50);

    // Out-of-range accesses and the DEPTH boundary.
    set_req(1, 1'b1, 8'h70, 64'h7070_7070_7070_7070); serve(60);
    set_req(1, 1'b1, 8'hF0, 64'h55);                  serve(60);
    set_req(1, 1'b0, 8'hF0, '0);                      serve(60);
    set_req(1, 1'b0, 8'h70, '0);                      serve(60);
    set_req(0, 1'b1, 8'd199, 64'h1990_0000_0000_0199); serve(60);
    set_req(0, 1'b0, 8'd199, '0);                     serve(60);
    set_req(0, 1'b1, 8'd200, 64'h2000);               serve(60);
    set_req(0, 1'b0, 8'd200, '0);                     serve(60);
    wait_idle(50);

    // Reset during WAIT of an accepted write: no response, write kept.
    set_req(0, 1'b1, 8'h05, 64'hA5);
    serve(60);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_req(0, 1'b0, 8'h05, '0);
    serve(60);
    wait_idle(50);

    // Randomised traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p] && !acc[p]) begin
          if ($urandom_range(0, 7) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          set_req(p, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
        end else begin
          req_valid[p] = 1'b0;
        end
      end
      resp_ready = NP'($urandom);
    end
    req_valid  = '0;
    resp_ready = '1;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_main_memory.md
Name: mp_main_memory

Overview:
- Parametrised, multi-port, line-granular shared main memory for the MESI cache system.
- Serves NUM_PORTS requestors (cache controllers / write-back path) through per-port valid/ready request and response channels.
- A round-robin arbiter serialises all accesses, which gives the coherence protocol a single global memory order.
- Access latency is programmable; out-of-range addresses are flagged rather than aliased.

Parameters:
- NUM_PORTS, 2, number of requestor ports (1..8).
- ADDR_W, 8, line-address width.
- LINE_W, 64, data width of one cache line.
- DEPTH, 256, number of lines implemented (<= 2**ADDR_W).
- LATENCY, 3, cycles from request acceptance to response valid (>= 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accept; one-hot or zero.
- req_we  in  NUM_PORTS  1 = write line, 0 = read line.
- req_addr  in  NUM_PORTS*ADDR_W  line address; port i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  write data; port i occupies slice [i*LINE_W +: LINE_W].
- resp_valid  out  NUM_PORTS  per-port response valid; one-hot or zero.
- resp_ready  in  NUM_PORTS  per-port response accept.
- resp_rdata  out  LINE_W  read data; shared across ports, qualified by resp_valid.
- resp_err  out  1  address >= DEPTH; qualified by resp_valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = IDLE; round-robin pointer = 0.
  - req_ready, resp_valid, resp_err, busy all = 0; resp_rdata = 0; latency counter = 0.
  - Memory array is not cleared; reads of unwritten lines return undefined data.
  - Reset asserted mid-transaction aborts it. A write already accepted remains committed. No response is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - The arbiter picks the first port with req_valid, scanning from the pointer upward modulo NUM_PORTS.
  - req_ready is driven combinationally high to that port only, and only in IDLE.
  - Handshake: req_valid && req_ready at the edge ending cycle T.
  - At that edge: latch port id, we, addr, err = (addr >= DEPTH); pointer <= (granted + 1) mod NUM_PORTS.
  - Write with !err: array[addr] <= wdata at the same edge.
  - Read with !err: data is captured from the array at the same edge, so a read sees all previously accepted writes.
  - Err access: no array write; rdata = 0.
  - Next state: WAIT if LATENCY > 1, else RESP.
- WAIT: the counter counts LATENCY-1 cycles, then the FSM moves to RESP.
- Latency: resp_valid[port] rises in cycle T+LATENCY.
- RESP:
  - resp_valid high only for the latched port.
  - resp_rdata = read data, or 0 for writes and errors; resp_err = latched err.
  - Outputs are held stable until resp_ready[port] is sampled high.
  - On that edge the FSM returns to IDLE and resp_valid falls next cycle.
  - Ready on other ports is ignored.
- Throughput: at most one transaction per LATENCY+1 cycles. There is no new acceptance in the cycle the response handshake completes; IDLE is always at least one cycle.
- Requesters must hold req_* stable while req_valid is high and not accepted. Dropping req_valid before acceptance is permitted; that port is simply skipped.
- Simultaneous requests: exactly one is granted and the losers see req_ready = 0. Fairness: a continuously requesting port waits at most NUM_PORTS-1 transactions.
- NUM_PORTS = 1: the arbiter degenerates and the pointer stays 0.
- Address wrap: none. Addresses in DEPTH..2**ADDR_W-1 return err and never alias.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with all req_valid = 1 -> req_ready = 0, resp_valid = 0, busy = 0 throughout. After release, port 0 is granted first.
- Write/read latency (LATENCY = 3): port 0 writes addr 0x10 data 0xDEADBEEF_01234567, accepted at cycle T -> resp_valid[0] at T+3 with rdata = 0, err = 0. A subsequent read of 0x10 returns 0xDEADBEEF_01234567 exactly 3 cycles after acceptance.
- Contention: ports 0 and 1 assert valid in the same cycle for 6 transactions each -> grants alternate 0,1,0,1,... and no port waits more than one transaction.
- Backpressure: hold resp_ready[1] = 0 for 5 cycles during a read of 0x20 -> resp_valid, rdata and err stay stable and busy = 1. Port 0 valid is not accepted until one cycle after the port-1 handshake.
- Error: DEPTH = 200; port 1 writes addr 0xF0 data 0x55, then reads 0xF0 -> both responses have err = 1 and rdata = 0. A read of 0x70 (0xF0 mod 128) is unchanged.
- Reset mid-op: assert reset during WAIT of an accepted write to 0x05 data 0xA5 -> no response. After release, reading 0x05 returns 0xA5.
